suma_direccion_pipe: RTL and testbench
======================================

// Module: suma_direccion_pipe
// PURPOSE
//  Parametrised, pipelined successor of the branch-target adder.
//  Computes result_suma = bus_direccion_im + (bus_out << DESPL) over WIDTH bits.
//  The carry chain is split into ETAPAS registered chunks, with valid/ready handshake on both sides.
//  Reports carry-out and signed overflow.
//  Sits between decode (immediate/offset) and the PC-select mux.
// PARAMETERS
//  WIDTH   64  operand/result width; must be divisible by ETAPAS
//  ETAPAS  2   pipeline stages, 1..4; stage k adds bit chunk k (WIDTH/ETAPAS bits, LSB chunk first)
//  DESPL   2   left shift applied to bus_out, 0..3; zero fill, bits shifted out are discarded
// PORTS
//  clk               in   1      rising-edge clock
//  reset             in   1      asynchronous, active-high reset
//  in_valid          in   1      operands valid
//  in_ready          out  1      block accepts operands this cycle
//  bus_direccion_im  in   WIDTH  operand A (current address)
//  bus_out           in   WIDTH  operand B (offset, pre-shift)
//  out_valid         out  1      result valid
//  out_ready         in   1      consumer accepts result
//  result_suma       out  WIDTH  sum
//  acarreo           out  1      carry out of bit WIDTH-1
//  desborde          out  1      signed overflow
// BEHAVIOUR
//  - Reset is asynchronous, active-high. On reset:
//    - all stage valid bits, out_valid, result_suma, acarreo and desborde go to 0;
//    - in_ready is 0 while reset is asserted;
//    - in-flight operations are discarded, not completed.
//  - Transfer in: in_valid && in_ready on a rising edge. Transfer out: out_valid && out_ready.
//  - Stage i advances when it holds data and (stage i+1 is empty or stage i+1 advances).
//    - The last stage advances when out_ready is high.
//    - in_ready = !stage0_valid || stage0_advances (combinational from out_ready through the chain).
//  - Latency: ETAPAS cycles from accept to out_valid with no stall. Throughput: 1 op per cycle.
//  - Bubbles collapse: an empty stage accepts data even while the output is stalled.
//  - While out_valid && !out_ready: result_suma, acarreo and desborde stay stable.
//  - Results leave in accept order; none are dropped or duplicated.
//  - Arithmetic: B' = (bus_out << DESPL)[WIDTH-1:0]; sum modulo 2^WIDTH.
//    - Chunk carry is registered into the next stage.
//    - Upper, not-yet-added chunks travel with the data.
//    - acarreo = carry out of the MSB chunk.
//    - desborde = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
//  - ETAPAS = 1: single registered adder, latency 1.
//  - Simultaneous in and out transfer on a full pipeline is legal and keeps it full.
// CONFIGURATION
//  SUMA_SAT_EN defined:
//    - when desborde = 1, result_suma clamps to 0x7FF..F for positive overflow
//      or 0x800..0 for negative overflow;
//    - desborde and acarreo are still reported;
//    - clamping happens in the last stage and adds no latency.
//  SUMA_SAT_EN undefined: result_suma wraps modulo 2^WIDTH.
// TESTING  (WIDTH=64, ETAPAS=2, DESPL=2 unless noted)
//  1. Reset held -> out_valid=0, result_suma=0, in_ready=0.
//     Release reset -> in_ready=1 in the first cycle after release.
//  2. A=0x1000, B=0x4, out_ready=1 -> result_suma=0x1010 with out_valid exactly 2 cycles after accept.
//     Also acarreo=0, desborde=0.
//  3. Chunk carry: A=0x0000_0000_FFFF_FFFC, B=0x1 -> 0x0000_0001_0000_0000.
//  4. 8 back-to-back ops, out_ready pattern 1,0,1,0,... ->
//     - all 8 sums arrive in order;
//     - outputs are stable during stalls;
//     - in_ready=0 only when both stages are full and out_ready=0.
//  5. A=0x7FFF_FFFF_FFFF_FFF0, B=0x8 ->
//     - 0x8000_0000_0000_0010, desborde=1 (no SUMA_SAT_EN);
//     - 0x7FFF_FFFF_FFFF_FFFF with SUMA_SAT_EN.
//     A=0xFFFF_FFFF_FFFF_FFFC, B=0x1 -> 0, acarreo=1, desborde=0.
//  6. Reset asserted with 2 ops in flight -> out_valid drops to 0 asynchronously.
//     After release no stale result appears; the next op (A=0x20, B=0x1) -> 0x24.

Source files
------------

// File: rtl/suma_direccion_pipe.sv
// rtl/suma_direccion_pipe.sv - pipelined A + (B << DESPL) adder with valid/ready, carry and overflow
// Optional SUMA_SAT_EN: clamp result_suma to the signed limits on overflow.
module suma_direccion_pipe #(
    parameter int WIDTH  = 64,
    parameter int ETAPAS = 2,
    parameter int DESPL  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] bus_direccion_im,
    input  logic [WIDTH-1:0] bus_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_suma,
    output logic             acarreo,
    output logic             desborde
);

    localparam int CH   = WIDTH / ETAPAS;
    localparam int LAST = ETAPAS - 1;

    logic [ETAPAS-1:0] valid_q, valid_d, adv, load;
    logic [WIDTH-1:0]  a_q [ETAPAS];
    logic [WIDTH-1:0]  b_q [ETAPAS];
    logic [WIDTH-1:0]  s_q [ETAPAS];
    logic [WIDTH-1:0]  a_d [ETAPAS];
    logic [WIDTH-1:0]  b_d [ETAPAS];
    logic [WIDTH-1:0]  s_d [ETAPAS];
    logic [ETAPAS-1:0] c_q, c_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  b_shift, a_cur, b_cur, s_cur;
    logic              c_cur;
    logic [CH:0]       chunk;

    // Advance decisions ripple back from out_ready so a full pipe can accept while draining.
    always_comb begin
        adv     = '0;
        load    = '0;
        valid_d = '0;
        for (int k = LAST; k >= 0; k--) begin
            if (k == LAST)
                adv[k] = valid_q[k] && out_ready;
            else
                adv[k] = valid_q[k] && (!valid_q[(k < LAST) ? k + 1 : LAST] ||
                                        adv[(k < LAST) ? k + 1 : LAST]);
        end
        in_ready = !reset && (!valid_q[0] || adv[0]);
        for (int k = 0; k < ETAPAS; k++) begin
            if (k == 0)
                load[k] = in_valid && in_ready;
            else
                load[k] = adv[(k > 0) ? k - 1 : 0];
            valid_d[k] = load[k] || (valid_q[k] && !adv[k]);
        end
    end

    // Stage k adds chunk k; operands and the partial sum travel with the data.
    always_comb begin
        b_shift = bus_out << DESPL;
        a_cur   = '0;
        b_cur   = '0;
        s_cur   = '0;
        c_cur   = 1'b0;
        chunk   = '0;
        ovf_d   = 1'b0;
        c_d     = '0;
        for (int k = 0; k < ETAPAS; k++) begin
            if (k == 0) begin
                a_cur = bus_direccion_im;
                b_cur = b_shift;
                s_cur = '0;
                c_cur = 1'b0;
            end else begin
                a_cur = a_q[(k > 0) ? k - 1 : 0];
                b_cur = b_q[(k > 0) ? k - 1 : 0];
                s_cur = s_q[(k > 0) ? k - 1 : 0];
                c_cur = c_q[(k > 0) ? k - 1 : 0];
            end
            chunk = {1'b0, a_cur[k*CH +: CH]} + {1'b0, b_cur[k*CH +: CH]} + {{CH{1'b0}}, c_cur};
            a_d[k] = a_cur;
            b_d[k] = b_cur;
            s_d[k] = s_cur;
            s_d[k][k*CH +: CH] = chunk[CH-1:0];
            c_d[k] = chunk[CH];
            if (k == LAST) begin
                ovf_d = (a_cur[WIDTH-1] == b_cur[WIDTH-1]) && (s_d[k][WIDTH-1] != a_cur[WIDTH-1]);
`ifdef SUMA_SAT_EN
                if (ovf_d)
                    s_d[k] = a_cur[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < ETAPAS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < ETAPAS; k++) begin
                if (load[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
            if (load[LAST])
                ovf_q <= ovf_d;
        end
    end

    assign out_valid   = valid_q[LAST];
    assign result_suma = s_q[LAST];
    assign acarreo     = c_q[LAST];
    assign desborde    = ovf_q;

endmodule

// File: tb/tb_suma_direccion_pipe.sv
// tb/tb_suma_direccion_pipe.sv - directed bench for suma_direccion_pipe (WIDTH=64, ETAPAS=2, DESPL=2)
module tb_suma_direccion_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, acarreo, desborde;
    logic [63:0] a, b, result_suma;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] s;
        logic        c;
        logic        v;
    } vec_t;

    vec_t tbl [8];

    suma_direccion_pipe #(.WIDTH(64), .ETAPAS(2), .DESPL(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .bus_direccion_im(a), .bus_out(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_suma(result_suma), .acarreo(acarreo), .desborde(desborde)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input int id, input vec_t t);
        int cyc;
        in_valid  = 1'b1;
        a         = t.a;
        b         = t.b;
        out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d in_ready", id), {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (out_valid) break;
        end
        chk($sformatf("v%0d latency", id), 64'(cyc), 64'd2);
        chk($sformatf("v%0d sum", id), result_suma, t.s);
        chk($sformatf("v%0d acarreo", id), {63'd0, acarreo}, {63'd0, t.c});
        chk($sformatf("v%0d desborde", id), {63'd0, desborde}, {63'd0, t.v});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_q [$];
        logic [63:0] held_s;
        logic        stalled, fin, fout;
        int          sent, rcv, occ, t;
        vec_t        v;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        repeat (2) @(negedge clk);
        chk("rst out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst result", result_suma, 64'd0);
        chk("rst in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post-rst in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        tbl[0] = '{64'h1000, 64'h4, 64'h1010, 1'b0, 1'b0};
        tbl[1] = '{64'h0000_0000_FFFF_FFFC, 64'h1, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
`ifdef SUMA_SAT_EN
        tbl[2] = '{64'h7FFF_FFFF_FFFF_FFF0, 64'h8, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        tbl[4] = '{64'h8000_0000_0000_0000, 64'h2000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
`else
        tbl[2] = '{64'h7FFF_FFFF_FFFF_FFF0, 64'h8, 64'h8000_0000_0000_0010, 1'b0, 1'b1};
        tbl[4] = '{64'h8000_0000_0000_0000, 64'h2000_0000_0000_0000, 64'h0, 1'b1, 1'b1};
`endif
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h1, 64'h0, 1'b1, 1'b0};
        tbl[5] = '{64'h1, 64'hC000_0000_0000_0001, 64'h5, 1'b0, 1'b0};
        tbl[6] = '{64'h0000_0000_FFFF_FFFF, 64'h3FFF_FFFF_C000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        tbl[7] = '{64'h0, 64'h0, 64'h0, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) do_op(i, tbl[i]);

        // Back-to-back stream with out_ready toggling 1,0,1,0...
        sent = 0; rcv = 0; occ = 0; t = 0; stalled = 1'b0; held_s = '0;
        while (rcv < 8 && t < 60) begin
            out_ready = (t % 2 == 0);
            in_valid  = (sent < 8);
            a         = 64'h0000_0000_FFFF_FFF0 + 64'(sent) * 64'h10;
            b         = 64'h0100_0000_0000_0000 * 64'(sent) + 64'(sent);
            @(negedge clk);
            if (stalled) begin
                chk($sformatf("stall t%0d out_valid", t), {63'd0, out_valid}, 64'd1);
                chk($sformatf("stall t%0d sum", t), result_suma, held_s);
            end
            chk($sformatf("stream t%0d in_ready", t), {63'd0, in_ready},
                {63'd0, !(occ == 2 && !out_ready)});
            fin  = in_valid && in_ready;
            fout = out_valid && out_ready;
            if (fout) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("stream t%0d unexpected", t), result_suma, 64'hDEAD);
                end else begin
                    chk($sformatf("stream r%0d sum", rcv), result_suma, exp_q.pop_front());
                end
                rcv++;
            end
            stalled = out_valid && !out_ready;
            held_s  = result_suma;
            if (fin) begin
                exp_q.push_back(a + (b << 2));
                sent++;
            end
            occ = occ + int'(fin) - int'(fout);
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        chk("stream received", 64'(rcv), 64'd8);

        // Two ops in flight, then asynchronous reset mid-cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 64'h100;
        b         = 64'h1;
        @(posedge clk);
        #1 a = 64'h200;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("inflight out_valid", {63'd0, out_valid}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async rst out_valid", {63'd0, out_valid}, 64'd0);
        chk("async rst result", result_suma, 64'd0);
        chk("async rst in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("no stale %0d", i), {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        v = '{64'h20, 64'h1, 64'h24, 1'b0, 1'b0};
        do_op(100, v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
